// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx
//   Memory-mapped UART transmitter on the processor data-memory bus.
//   Stores to DATA (BASE_ADDR) queue a byte in a small FIFO; the FSM
//   serialises each byte LSB first as 8N1 (8E1 in the parity build) on TxD.
//   Loads from STATUS (BASE_ADDR+4) return the status word combinationally.
//   Stores to STATUS clear the sticky overflow flag.
//
// Ports
//   clk        system clock, all state on rising edge
//   reset      asynchronous, active-high, clears all state
//   Address    byte address from the ALU (bits [1:0] ignored by decode)
//   WriteData  store data, only [7:0] used
//   MemWrite   store strobe
//   MemRead    load strobe, qualifies ReadData
//   ReadData   STATUS word on a STATUS load, otherwise 0 (OR-able into load mux)
//   TxD        serial line, idle high, driven from a flop
//   TxBusy     high while the FSM is active or the FIFO holds data
//
// STATUS word
//   [0] busy (FSM not idle)  [1] full  [2] empty  [3] overflow
//   [10:4] count  [11] parity build flag  [31:12] zero
//
// Build option
//   MMIO_UART_TX_PARITY_EN : inserts an even-parity bit between the data
//   bits and the stop bit, and sets STATUS[11].

module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR  = 32'hFFFF_0000,
    parameter int          BAUD_DIV   = 434,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    input  logic        MemRead,
    output logic [31:0] ReadData,
    output logic        TxD,
    output logic        TxBusy
);

    localparam int          AW          = $clog2(FIFO_DEPTH);
    localparam logic [31:0] STATUS_ADDR = BASE_ADDR + 32'd4;
    localparam logic [15:0] BAUD_LAST   = 16'(BAUD_DIV - 1);
`ifdef MMIO_UART_TX_PARITY_EN
    localparam logic        PARITY_FLAG = 1'b1;
`else
    localparam logic        PARITY_FLAG = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // ---------------- registers ----------------
    state_t      r_state;
    logic [15:0] r_baud_cnt;
    logic [2:0]  r_bit_cnt;
    logic [7:0]  r_shift;
    logic        r_txd;
    logic        r_overflow;
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic [7:0]  r_mem [FIFO_DEPTH];
`ifdef MMIO_UART_TX_PARITY_EN
    logic        r_parity;
`endif

    // ---------------- wires ----------------
    state_t      w_state_next;
    logic [15:0] w_baud_next;
    logic [2:0]  w_bit_next;
    logic [7:0]  w_shift_next;
    logic        w_txd_next;
    logic        w_pop;
    logic        w_baud_wrap;
    logic        w_full;
    logic        w_empty;
    logic [AW:0] w_count;
    logic [7:0]  w_head;
    logic        w_data_sel;
    logic        w_stat_sel;
    logic        w_push_req;
    logic        w_push;
    logic        w_ovf_set;
    logic        w_ovf_clr;
    logic [31:0] w_status;
    logic        w_unused_bits;

    assign w_unused_bits = ^{WriteData[31:8], Address[1:0]};

    // ---------------- address decode / FIFO flags ----------------
    assign w_data_sel = (Address[31:2] == BASE_ADDR[31:2]);
    assign w_stat_sel = (Address[31:2] == STATUS_ADDR[31:2]);

    assign w_count = r_wr_ptr - r_rd_ptr;
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_head  = r_mem[r_rd_ptr[AW-1:0]];

    // Fullness is judged before the edge, so a same-edge pop cannot make room.
    assign w_push_req = MemWrite && w_data_sel;
    assign w_push     = w_push_req && !w_full;
    assign w_ovf_set  = w_push_req && w_full;
    assign w_ovf_clr  = MemWrite && w_stat_sel;

    assign w_baud_wrap = (r_baud_cnt == BAUD_LAST);

    // ---------------- FSM next state ----------------
    // w_txd_next is the line level for the coming cycle, so TxD comes
    // straight from a flop and changes on the same edge as the state.
    always_comb begin
        w_state_next = r_state;
        w_baud_next  = w_baud_wrap ? 16'd0 : r_baud_cnt + 16'd1;
        w_bit_next   = r_bit_cnt;
        w_shift_next = r_shift;
        w_txd_next   = r_txd;
        w_pop        = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_baud_next = 16'd0;
                w_txd_next  = 1'b1;
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_shift_next = w_head;
                    w_state_next = S_START;
                    w_txd_next   = 1'b0;
                end
            end
            S_START: begin
                if (w_baud_wrap) begin
                    w_state_next = S_DATA;
                    w_bit_next   = 3'd0;
                    w_txd_next   = r_shift[0];
                end
            end
            S_DATA: begin
                if (w_baud_wrap) begin
                    if (r_bit_cnt == 3'd7) begin
`ifdef MMIO_UART_TX_PARITY_EN
                        w_state_next = S_PARITY;
                        w_txd_next   = r_parity;
`else
                        w_state_next = S_STOP;
                        w_txd_next   = 1'b1;
`endif
                    end else begin
                        w_bit_next   = r_bit_cnt + 3'd1;
                        w_shift_next = {1'b0, r_shift[7:1]};
                        w_txd_next   = r_shift[1];
                    end
                end
            end
`ifdef MMIO_UART_TX_PARITY_EN
            S_PARITY: begin
                if (w_baud_wrap) begin
                    w_state_next = S_STOP;
                    w_txd_next   = 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (w_baud_wrap) begin
                    // Chain straight into the next start bit when data waits.
                    if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_shift_next = w_head;
                        w_state_next = S_START;
                        w_txd_next   = 1'b0;
                    end else begin
                        w_state_next = S_IDLE;
                        w_txd_next   = 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_txd_next   = 1'b1;
            end
        endcase
    end

    // ---------------- state registers ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_baud_cnt <= 16'd0;
            r_bit_cnt  <= 3'd0;
            r_shift    <= 8'd0;
            r_txd      <= 1'b1;
            r_overflow <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
        end else begin
            r_state    <= w_state_next;
            r_baud_cnt <= w_baud_next;
            r_bit_cnt  <= w_bit_next;
            r_shift    <= w_shift_next;
            r_txd      <= w_txd_next;
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_ovf_set)
                r_overflow <= 1'b1;
            else if (w_ovf_clr)
                r_overflow <= 1'b0;
        end
    end

`ifdef MMIO_UART_TX_PARITY_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_parity <= 1'b0;
        else if (w_pop)
            r_parity <= ^w_head;
    end
`endif

    // FIFO storage needs no reset: the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr[AW-1:0]] <= WriteData[7:0];
    end

    // ---------------- outputs ----------------
    assign w_status = {20'd0, PARITY_FLAG, 7'(w_count), r_overflow,
                       w_empty, w_full, (r_state != S_IDLE)};
    assign ReadData = (MemRead && w_stat_sel) ? w_status : 32'd0;
    assign TxD      = r_txd;
    assign TxBusy   = (r_state != S_IDLE) || !w_empty;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed testbench for mmio_uart_tx (BAUD_DIV=4, FIFO_DEPTH=4).
// A vector table covers register decode at idle; hand-written sequences
// cover frame timing, back-to-back bytes, overflow and reset mid-frame.
module tb_mmio_uart_tx;

    localparam logic [31:0] BASE = 32'hFFFF_0000;
    localparam int          DIV  = 4;
`ifdef MMIO_UART_TX_PARITY_EN
    localparam int          NB   = 11;
    localparam logic [31:0] PF   = 32'h0000_0800;
`else
    localparam int          NB   = 10;
    localparam logic [31:0] PF   = 32'h0000_0000;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] Address = 32'd0;
    logic [31:0] WriteData = 32'd0;
    logic        MemWrite = 1'b0;
    logic        MemRead = 1'b0;
    logic [31:0] ReadData;
    logic        TxD;
    logic        TxBusy;

    int total = 0;
    int bad = 0;

    mmio_uart_tx #(
        .BASE_ADDR (BASE),
        .BAUD_DIV  (DIV),
        .FIFO_DEPTH(4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .Address  (Address),
        .WriteData(WriteData),
        .MemWrite (MemWrite),
        .MemRead  (MemRead),
        .ReadData (ReadData),
        .TxD      (TxD),
        .TxBusy   (TxBusy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic        re;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vt[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Line level expected for bit slot idx of a frame carrying byte b.
    function automatic logic exp_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
        if (NB == 11 && idx == 9) return ^b;
        return 1'b1;
    endfunction

    // Called between the edge that makes the line go low (minus one) and
    // that edge; samples every cycle of the frame at the falling edge.
    task automatic check_frame(input logic [7:0] b, input string tag);
        for (int k = 0; k < NB * DIV; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("%s slot%0d cyc%0d", tag, k / DIV, k % DIV),
                {31'd0, TxD}, {31'd0, exp_bit(b, k / DIV)});
        end
    endtask

    task automatic read_status(input string name, input logic [31:0] exp);
        Address = BASE + 32'd4;
        MemRead = 1'b1;
        #1;
        chk(name, ReadData, exp);
        MemRead = 1'b0;
        Address = 32'd0;
    endtask

    // Single store; returns 1 ns after the capturing edge.
    task automatic store_edge(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        Address   = addr;
        WriteData = data;
        MemWrite  = 1'b1;
        @(posedge clk);
        #1;
        MemWrite = 1'b0;
        Address  = 32'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int quiet_errs;

        vt[0] = '{BASE + 32'h8,  32'h55, 1'b1, 1'b0, 32'h0};
        vt[1] = '{BASE,          32'h0,  1'b0, 1'b1, 32'h0};
        vt[2] = '{BASE + 32'h4,  32'h0,  1'b0, 1'b1, 32'h4 | PF};
        vt[3] = '{BASE + 32'h6,  32'h0,  1'b0, 1'b1, 32'h4 | PF};
        vt[4] = '{BASE + 32'h8,  32'h0,  1'b0, 1'b1, 32'h0};
        vt[5] = '{BASE + 32'h4,  32'h0,  1'b0, 1'b0, 32'h0};
        vt[6] = '{32'h0,         32'hA5, 1'b1, 1'b0, 32'h0};
        vt[7] = '{BASE + 32'h10, 32'h3C, 1'b1, 1'b1, 32'h0};
        vt[8] = '{BASE + 32'h4,  32'hFF, 1'b1, 1'b1, 32'h4 | PF};

        // ---- reset ----
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("in reset TxD/TxBusy", {30'd0, TxBusy, TxD}, 32'h1);
        reset = 1'b0;
        @(negedge clk);
        chk("after reset TxD/TxBusy", {30'd0, TxBusy, TxD}, 32'h1);
        read_status("after reset STATUS", 32'h4 | PF);

        // ---- decode table at idle ----
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            Address   = vt[i].addr;
            WriteData = vt[i].wdata;
            MemWrite  = vt[i].we;
            MemRead   = vt[i].re;
            #1;
            chk($sformatf("vec%0d ReadData", i), ReadData, vt[i].exp_rd);
            @(posedge clk);
            #1;
            MemWrite = 1'b0;
            MemRead  = 1'b0;
            Address  = 32'd0;
            @(negedge clk);
            chk($sformatf("vec%0d line idle", i), {30'd0, TxBusy, TxD}, 32'h1);
        end
        read_status("after table STATUS", 32'h4 | PF);

        // ---- single byte 0xA5 ----
        store_edge(BASE, 32'hA5);
        chk("A5 push line still high", {31'd0, TxD}, 32'h1);
        chk("A5 push TxBusy", {31'd0, TxBusy}, 32'h1);
        read_status("A5 queued STATUS", 32'h10 | PF);
        check_frame(8'hA5, "A5");
        chk("A5 busy in last stop cycle", {31'd0, TxBusy}, 32'h1);
        @(posedge clk);
        @(negedge clk);
        chk("A5 done TxD/TxBusy", {30'd0, TxBusy, TxD}, 32'h1);
        read_status("A5 done STATUS", 32'h4 | PF);

        // ---- six back-to-back stores, overflow ----
        @(negedge clk);
        Address   = BASE;
        WriteData = 32'h01;
        MemWrite  = 1'b1;
        @(posedge clk);
        #1;
        fork
            begin
                for (int i = 2; i <= 6; i++) begin
                    WriteData = i;
                    @(posedge clk);
                    #1;
                end
                MemWrite = 1'b0;
                Address  = 32'd0;
                read_status("burst full+ovf STATUS", 32'h4B | PF);
            end
            begin
                for (int j = 1; j <= 5; j++)
                    check_frame(8'(j), $sformatf("burst%0d", j));
            end
        join
        chk("burst busy in last stop cycle", {31'd0, TxBusy}, 32'h1);
        @(posedge clk);
        @(negedge clk);
        chk("burst done TxD/TxBusy", {30'd0, TxBusy, TxD}, 32'h1);
        read_status("burst done STATUS", 32'hC | PF);
        store_edge(BASE + 32'h4, 32'h0);
        read_status("overflow cleared STATUS", 32'h4 | PF);

        // ---- reset mid-frame ----
        @(negedge clk);
        Address   = BASE;
        WriteData = 32'h3C;
        MemWrite  = 1'b1;
        @(posedge clk);
        #1;
        WriteData = 32'h11;
        @(posedge clk);
        #1;
        WriteData = 32'h22;
        @(posedge clk);
        #1;
        MemWrite = 1'b0;
        Address  = 32'd0;
        read_status("3C two queued STATUS", 32'h21 | PF);
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("3C mid data bit1 low", {31'd0, TxD}, 32'h0);
        #1;
        reset = 1'b1;
        #1;
        chk("async reset TxD high", {31'd0, TxD}, 32'h1);
        chk("async reset TxBusy", {31'd0, TxBusy}, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        read_status("post reset STATUS", 32'h4 | PF);
        quiet_errs = 0;
        repeat (60) begin
            @(negedge clk);
            if (TxD !== 1'b1 || TxBusy !== 1'b0) quiet_errs++;
        end
        chk("no output after reset", quiet_errs, 32'h0);

        // ---- byte 0x07 (odd popcount: parity slot is 1 when enabled) ----
        store_edge(BASE, 32'h07);
        check_frame(8'h07, "07");
        @(posedge clk);
        @(negedge clk);
        chk("07 done TxD/TxBusy", {30'd0, TxBusy, TxD}, 32'h1);
        read_status("07 done STATUS", 32'h4 | PF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
